// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and PC helper for the branch predictor
package branch_predictor_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT = 2'b00;
  localparam bp_ctr_t BP_WNT = 2'b01;
  localparam bp_ctr_t BP_WT  = 2'b10;
  localparam bp_ctr_t BP_ST  = 2'b11;

  function automatic logic [31:0] bp_pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, execute update and redirect signals of the predictor
interface branch_predictor_if;

  logic        fetch_valid_i;
  logic [31:0] fetch_pc_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;

  modport slave (
    input  fetch_valid_i, fetch_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o
  );

  modport master (
    output fetch_valid_i, fetch_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_valid_o, pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - 2-bit saturating direction counter next-state function
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != BP_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != BP_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, fetch prediction and execute redirect
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input logic                 clk,
  input logic                 reset,
  branch_predictor_if.slave   bp
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    bp_ctr_t          ctr;
  } bp_entry_t;

  bp_entry_t   table_q [NUM_ENTRIES];
  bp_entry_t   table_d [NUM_ENTRIES];
  logic        pred_valid_q, pred_valid_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  bp_entry_t        f_entry, u_entry;
  logic             f_hit, u_hit;
  bp_ctr_t          u_ctr_next;

  assign f_idx   = bp.fetch_pc_i[IDX_W+1:2];
  assign u_idx   = bp.upd_pc_i[IDX_W+1:2];
  assign f_entry = table_q[f_idx];
  assign u_entry = table_q[u_idx];
  assign f_hit   = f_entry.valid && (f_entry.tag == bp.fetch_pc_i[31:IDX_W+2]);
  assign u_hit   = u_entry.valid && (u_entry.tag == bp.upd_pc_i[31:IDX_W+2]);

  bp_sat_counter u_sat_counter (
    .ctr_i   (u_entry.ctr),
    .taken_i (bp.upd_taken_i),
    .ctr_o   (u_ctr_next)
  );

  // Lookup reads table_q, so a same-cycle update to the same index is seen only from the next lookup.
  always_comb begin
    table_d = table_q;
    if (bp.upd_valid_i) begin
      if (u_hit) begin
        table_d[u_idx].ctr = u_ctr_next;
        if (bp.upd_taken_i) table_d[u_idx].target = bp.upd_target_i;
      end else if (bp.upd_taken_i) begin
        table_d[u_idx].valid  = 1'b1;
        table_d[u_idx].tag    = bp.upd_pc_i[31:IDX_W+2];
        table_d[u_idx].target = bp.upd_target_i;
        table_d[u_idx].ctr    = BP_WT;
      end
    end
  end

  always_comb begin
    pred_valid_d  = bp.fetch_valid_i;
    pred_taken_d  = bp.fetch_valid_i && f_hit && f_entry.ctr[1];
    pred_target_d = pred_target_q;
    if (bp.fetch_valid_i)
      pred_target_d = pred_taken_d ? f_entry.target : bp_pc_plus4(bp.fetch_pc_i);

    mispredict_d  = bp.upd_valid_i &&
                    ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
                     (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i)));
    redirect_pc_d = redirect_pc_q;
    if (bp.upd_valid_i)
      redirect_pc_d = bp.upd_taken_i ? bp.upd_target_i : bp_pc_plus4(bp.upd_pc_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WNT};
      end
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      table_q       <= table_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bp.pred_valid_o  = pred_valid_q;
  assign bp.pred_taken_o  = pred_taken_q;
  assign bp.pred_target_o = pred_target_q;
  assign bp.mispredict_o  = mispredict_q;
  assign bp.redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  branch_predictor_if bp ();

  branch_predictor #(.NUM_ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bp.fetch_valid_i     = 1'b0;
    bp.fetch_pc_i        = 32'h0;
    bp.upd_valid_i       = 1'b0;
    bp.upd_pc_i          = 32'h0;
    bp.upd_taken_i       = 1'b0;
    bp.upd_target_i      = 32'h0;
    bp.upd_pred_taken_i  = 1'b0;
    bp.upd_pred_target_i = 32'h0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bp.fetch_valid_i = 1'b1;
    bp.fetch_pc_i    = pc;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    bp.upd_valid_i       = 1'b1;
    bp.upd_pc_i          = pc;
    bp.upd_taken_i       = tk;
    bp.upd_target_i      = tgt;
    bp.upd_pred_taken_i  = ptk;
    bp.upd_pred_target_i = ptgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    fetch(32'h100);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o} !== 67'h0) begin
      $display("FAIL reset_outputs got v=%0b t=%0b tgt=%h m=%0b r=%h required all zero",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    reset = 1'b0;
  endtask

  task automatic test_cold_lookup();
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 1'b0, 32'h104}) begin
      $display("FAIL cold_lookup got v=%0b t=%0b tgt=%h required v=1 t=0 tgt=00000104",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o} !== {1'b0, 1'b0, 32'h104}) begin
      $display("FAIL pred_hold got v=%0b t=%0b tgt=%h required v=0 t=0 tgt=00000104",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
  endtask

  task automatic test_allocate();
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    n_vec++;
    if ({bp.mispredict_o, bp.redirect_pc_o} !== {1'b1, 32'h80}) begin
      $display("FAIL alloc_redirect got m=%0b r=%h required m=1 r=00000080", bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o} !==
        {1'b1, 1'b1, 32'h80, 1'b0, 32'h80}) begin
      $display("FAIL alloc_lookup got v=%0b t=%0b tgt=%h m=%0b r=%h required v=1 t=1 tgt=00000080 m=0 r=00000080",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      step();
      n_vec++;
      if (bp.mispredict_o !== 1'b0) begin
        $display("FAIL sat_correct_%0d got m=%0b required m=0", i, bp.mispredict_o);
        n_err++;
      end
    end
    upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    n_vec++;
    if ({bp.mispredict_o, bp.redirect_pc_o} !== {1'b1, 32'h104}) begin
      $display("FAIL sat_nt1_redirect got m=%0b r=%h required m=1 r=00000104", bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 32'h80}) begin
      $display("FAIL sat_nt1_still_taken got t=%0b tgt=%h required t=1 tgt=00000080", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b0, 32'h104}) begin
      $display("FAIL sat_nt2_not_taken got t=%0b tgt=%h required t=0 tgt=00000104", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
  endtask

  task automatic test_alias();
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    fetch(32'h140);
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 1'b0, 32'h144}) begin
      $display("FAIL alias_miss got v=%0b t=%0b tgt=%h required v=1 t=0 tgt=00000144",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    upd(32'h140, 1'b0, 32'h0, 1'b0, 32'h144);
    step();
    n_vec++;
    if ({bp.mispredict_o, bp.redirect_pc_o} !== {1'b0, 32'h144}) begin
      $display("FAIL alias_nt_upd got m=%0b r=%h required m=0 r=00000144", bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 32'h80}) begin
      $display("FAIL alias_no_alloc got t=%0b tgt=%h required t=1 tgt=00000080", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    step();
    n_vec++;
    if ({bp.mispredict_o, bp.redirect_pc_o} !== {1'b1, 32'h200}) begin
      $display("FAIL alias_evict_redirect got m=%0b r=%h required m=1 r=00000200", bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b0, 32'h104}) begin
      $display("FAIL alias_evicted got t=%0b tgt=%h required t=0 tgt=00000104", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    fetch(32'h140);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 32'h200}) begin
      $display("FAIL alias_new_owner got t=%0b tgt=%h required t=1 tgt=00000200", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    fetch(32'h100);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o} !==
        {1'b1, 1'b0, 32'h104, 1'b1, 32'h80}) begin
      $display("FAIL same_cycle_old got v=%0b t=%0b tgt=%h m=%0b r=%h required v=1 t=0 tgt=00000104 m=1 r=00000080",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 32'h80}) begin
      $display("FAIL same_cycle_new got t=%0b tgt=%h required t=1 tgt=00000080", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    fetch(32'hFFFF_FFFC);
    upd(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o} !== {1'b0, 32'h0, 1'b1, 32'h0}) begin
      $display("FAIL pc_wrap got t=%0b tgt=%h m=%0b r=%h required t=0 tgt=00000000 m=1 r=00000000",
               bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    upd(32'h100, 1'b1, 32'h88, 1'b1, 32'h80);
    step();
    n_vec++;
    if ({bp.mispredict_o, bp.redirect_pc_o} !== {1'b1, 32'h88}) begin
      $display("FAIL target_mispredict got m=%0b r=%h required m=1 r=00000088", bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    fetch(32'h102);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 32'h88}) begin
      $display("FAIL target_updated got t=%0b tgt=%h required t=1 tgt=00000088", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    fetch(32'h100);
    upd(32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o} !== 67'h0) begin
      $display("FAIL reset_mid_outputs got v=%0b t=%0b tgt=%h m=%0b r=%h required all zero",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o, bp.redirect_pc_o);
      n_err++;
    end
    reset = 1'b0;
    fetch(32'h300);
    step();
    n_vec++;
    if ({bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o} !== {1'b1, 1'b0, 32'h304}) begin
      $display("FAIL reset_mid_no_alloc got v=%0b t=%0b tgt=%h required v=1 t=0 tgt=00000304",
               bp.pred_valid_o, bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
    fetch(32'h100);
    step();
    n_vec++;
    if ({bp.pred_taken_o, bp.pred_target_o} !== {1'b0, 32'h104}) begin
      $display("FAIL reset_mid_cleared got t=%0b tgt=%h required t=0 tgt=00000104", bp.pred_taken_o, bp.pred_target_o);
      n_err++;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_cold_lookup();
    test_allocate();
    test_saturation();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
